// File: rtl/retire_rat_pkg.sv
// Package for the retire RAT: re-exports the micro-op widths as typed constants.
// Optional same-cycle free bypass is enabled with the RETIRE_RAT_BYPASS_EN macro.
package retire_rat_pkg;
`include "micro_op.svh"

  localparam int ARF_INT_SIZE       = `ARF_INT_SIZE;
  localparam int ARF_INT_INDEX_SIZE = `ARF_INT_INDEX_SIZE;
  localparam int PRF_INT_INDEX_SIZE = `PRF_INT_INDEX_SIZE;
  localparam int RENAME_WIDTH       = `RENAME_WIDTH;
endpackage

// File: rtl/micro_op.svh
// Shared micro-op widths and the commit packet layout used by the commit-side blocks.
`ifndef MICRO_OP_SVH
`define MICRO_OP_SVH

`define ARF_INT_SIZE       32
`define ARF_INT_INDEX_SIZE 5
`define PRF_INT_INDEX_SIZE 6
`define RENAME_WIDTH       2

typedef struct packed {
  logic [`ARF_INT_INDEX_SIZE-1:0] rd;
  logic [`PRF_INT_INDEX_SIZE-1:0] prd;
  logic [`PRF_INT_INDEX_SIZE-1:0] prev_rd;
  logic                           prev_rd_valid;
} commit_pkt_t;

`endif

// File: rtl/retire_free_fifo.sv
// Multi-push / multi-pop circular buffer of freed PRF indices; pushes are compacted in lane order.
// With RETIRE_RAT_BYPASS_EN, pushes into an empty buffer may leave on pop_* in the same cycle.
module retire_free_fifo #(
  parameter int DEPTH  = 16,
  parameter int PUSH_W = 2,
  parameter int POP_W  = 2,
  parameter int W      = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [PUSH_W-1:0]             push_valid,
  input  logic [PUSH_W-1:0][W-1:0]      push_data,
  output logic [POP_W-1:0]              pop_valid,
  output logic [POP_W-1:0][W-1:0]       pop_data,
  output logic [$clog2(DEPTH):0]        count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]                    mem [DEPTH];
  logic [PTR_W-1:0]                head;
  logic [PTR_W-1:0]                tail;
  logic [PUSH_W-1:0][CNT_W-1:0]    slot;
  logic [CNT_W-1:0]                n_push;
  logic [CNT_W-1:0]                n_skip;
  logic [CNT_W-1:0]                n_pop;
  logic [PUSH_W-1:0]               wr_en;
  logic [PUSH_W-1:0][PTR_W-1:0]    wr_idx;

  always_comb begin
    // slot[i] = number of valid pushes in lower lanes, which removes holes
    n_push = '0;
    for (int i = 0; i < PUSH_W; i++) begin
      slot[i] = n_push;
      if (push_valid[i]) n_push = n_push + CNT_W'(1);
    end

    n_pop = (count < CNT_W'(POP_W)) ? count : CNT_W'(POP_W);
    for (int k = 0; k < POP_W; k++) begin
      pop_valid[k] = CNT_W'(k) < count;
      pop_data[k]  = mem[head + PTR_W'(k)];
    end

    n_skip = '0;
`ifdef RETIRE_RAT_BYPASS_EN
    if (count == '0) begin
      n_skip = (n_push < CNT_W'(POP_W)) ? n_push : CNT_W'(POP_W);
      for (int k = 0; k < POP_W; k++) begin
        pop_valid[k] = 1'b0;
        pop_data[k]  = '0;
        for (int i = 0; i < PUSH_W; i++) begin
          if (push_valid[i] && slot[i] == CNT_W'(k)) begin
            pop_valid[k] = 1'b1;
            pop_data[k]  = push_data[i];
          end
        end
      end
    end
`endif

    for (int i = 0; i < PUSH_W; i++) begin
      wr_en[i]  = push_valid[i] && (slot[i] >= n_skip);
      wr_idx[i] = tail + PTR_W'(slot[i] - n_skip);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_pop);
      tail  <= tail + PTR_W'(n_push - n_skip);
      count <= count + n_push - n_skip - n_pop;
    end
  end

  // Storage needs no reset: entries are only observed between head and tail.
  always_ff @(posedge clock) begin
    for (int i = 0; i < PUSH_W; i++) begin
      if (wr_en[i]) mem[wr_idx[i]] <= push_data[i];
    end
  end
endmodule

// File: rtl/retire_rat.sv
// Retirement RAT: holds the committed ARF->PRF map and returns each committing uop's prev_rd
// to the integer freelist through a release FIFO (bypass option: RETIRE_RAT_BYPASS_EN).
module retire_rat
  import retire_rat_pkg::*;
#(
  parameter int COMMIT_WIDTH  = RENAME_WIDTH,
  parameter int RELEASE_WIDTH = RENAME_WIDTH,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic [COMMIT_WIDTH-1:0]                           commit_valid,
  input  logic [COMMIT_WIDTH-1:0][ARF_INT_INDEX_SIZE-1:0]   commit_rd,
  input  logic [COMMIT_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   commit_prd,
  input  logic [COMMIT_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]   commit_prev_rd,
  input  logic [COMMIT_WIDTH-1:0]                           commit_prev_rd_valid,
  output logic                                              commit_ready,
  output logic [RELEASE_WIDTH-1:0]                          release_valid,
  output logic [RELEASE_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0]  release_prf,
  output logic [ARF_INT_SIZE-1:0][PRF_INT_INDEX_SIZE-1:0]   arch_map,
  output logic [$clog2(FIFO_DEPTH):0]                       fifo_count
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  commit_pkt_t [COMMIT_WIDTH-1:0]                  pkt;
  logic [COMMIT_WIDTH-1:0]                         push_valid;
  logic [COMMIT_WIDTH-1:0][PRF_INT_INDEX_SIZE-1:0] push_data;

  // Handshake: the commit bundle is consumed on any edge where commit_ready=1; lanes offered
  // while commit_ready=0 are ignored and the ROB holds them. release_* has no ready: the
  // freelist always accepts, so every valid release lane is a pop.
  assign commit_ready = (CNT_W'(FIFO_DEPTH) - fifo_count) >= CNT_W'(COMMIT_WIDTH);

  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      pkt[i].rd            = commit_rd[i];
      pkt[i].prd           = commit_prd[i];
      pkt[i].prev_rd       = commit_prev_rd[i];
      pkt[i].prev_rd_valid = commit_prev_rd_valid[i];
      push_valid[i]        = commit_ready && commit_valid[i] && pkt[i].prev_rd_valid;
      push_data[i]         = pkt[i].prev_rd;
    end
  end

  // Later lanes are assigned last, so the highest lane wins when rds collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      arch_map <= '0;
    end else if (commit_ready) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (commit_valid[i]) arch_map[pkt[i].rd] <= pkt[i].prd;
      end
    end
  end

  retire_free_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .PUSH_W (COMMIT_WIDTH),
    .POP_W  (RELEASE_WIDTH),
    .W      (PRF_INT_INDEX_SIZE)
  ) u_free_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_valid),
    .push_data  (push_data),
    .pop_valid  (release_valid),
    .pop_data   (release_prf),
    .count      (fifo_count)
  );
endmodule
